// File: rtl/spi_slave_full.sv
// spi_slave_full: SPI receive slave, MSB-first frame in on mosi, preloaded response out on miso
module spi_slave_full #(
  parameter int WIDTH = 392,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             abort,
  output logic             buzy
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t state_q, state_d;
  logic cs_q, sclk_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, data_out_q, data_out_d;
  logic done_q, done_d, abort_q, abort_d;
  logic cs_fall, cs_rise, sclk_fall;
  assign cs_fall   = cs_q & ~cs;
  assign cs_rise   = ~cs_q & cs;
  assign sclk_fall = sclk_q & ~sclk;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    case (state_q)
      IDLE: if (cs_fall) begin
        tx_sr_d = tx_data;
        cnt_d   = '0;
        rx_sr_d = '0;
        state_d = SHIFT;
      end
      SHIFT: if (cs_rise) begin
        abort_d = cnt_q != '0;
        state_d = IDLE;
      end else if (sclk_fall) begin
        rx_sr_d = {rx_sr_q[WIDTH-2:0], mosi};
        tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          data_out_d = {rx_sr_q[WIDTH-2:0], mosi};
          done_d     = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: state_d = cs_rise ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      cnt_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_q       <= cs;
      sclk_q     <= sclk;
      cnt_q      <= cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end
  assign miso     = (state_q == SHIFT) ? tx_sr_q[WIDTH-1] : 1'b0;
  assign buzy     = state_q == SHIFT;
  assign data_out = data_out_q;
  assign done     = done_q;
  assign abort    = abort_q;
endmodule
